// File: rtl/cpu_prog_mem_responder.sv
// cpu_prog_mem_responder: byte-array responder for the CPU bus, filled through a 3-wire serial loader
module cpu_prog_mem_responder #(
  parameter int ADDR_W = 10,
  parameter int DEPTH = 64,
  parameter logic [7:0] FILL = 8'h00,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] addr_bus,
  output logic [7:0]        data_bus,
  input  logic              ld_cs_n,
  input  logic              ld_sclk,
  input  logic              ld_sdi,
  output logic              cpu_hold,
  output logic [CW-1:0]     ld_count
);
  typedef enum logic [1:0] {IDLE, SHIFT, WRITE} state_t;
  state_t state, state_nxt;
  logic [1:0] cs_sync, sdi_sync;
  logic [2:0] sclk_sync;
  logic cs_q, cs_s, sdi_s, cs_rise, cs_fall, sclk_rise, hit;
  logic released, released_nxt;
  logic [AW-1:0] ptr, ptr_nxt;
  logic [2:0] bit_cnt, bit_cnt_nxt;
  logic [7:0] shift, shift_nxt;
  logic [CW-1:0] ld_count_nxt, ld_count_inc;
  logic [7:0] mem [DEPTH];
  assign cs_s = cs_sync[1];
  assign sdi_s = sdi_sync[1];
  assign cs_rise = cs_s & ~cs_q;
  assign cs_fall = ~cs_s & cs_q;
  assign sclk_rise = sclk_sync[1] & ~sclk_sync[2];
  assign ld_count_inc = (ld_count == CW'(DEPTH)) ? ld_count : ld_count + 1'b1;
  // Upper address bits must be clear: out-of-range reads return FILL, never an alias
  assign hit = (addr_bus >> AW) == '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_sync <= 2'b11;
      cs_q <= 1'b1;
      sclk_sync <= '0;
      sdi_sync <= '0;
      state <= IDLE;
      released <= 1'b0;
      ptr <= '0;
      bit_cnt <= '0;
      shift <= '0;
      ld_count <= '0;
      cpu_hold <= 1'b1;
      data_bus <= 8'h00;
    end else begin
      cs_sync <= {cs_sync[0], ld_cs_n};
      cs_q <= cs_s;
      sclk_sync <= {sclk_sync[1:0], ld_sclk};
      sdi_sync <= {sdi_sync[0], ld_sdi};
      state <= state_nxt;
      released <= released_nxt;
      ptr <= ptr_nxt;
      bit_cnt <= bit_cnt_nxt;
      shift <= shift_nxt;
      ld_count <= ld_count_nxt;
      cpu_hold <= (state == IDLE) ? ~released : 1'b1;
      data_bus <= hit ? mem[addr_bus[AW-1:0]] : FILL;
    end
  end
  always_ff @(posedge clk) begin
    if (state == WRITE) mem[ptr] <= shift;
  end
  always_comb begin
    state_nxt = state;
    released_nxt = released;
    ptr_nxt = ptr;
    bit_cnt_nxt = bit_cnt;
    shift_nxt = shift;
    ld_count_nxt = ld_count;
    case (state)
      IDLE: if (cs_fall) begin
        state_nxt = SHIFT;
        ptr_nxt = '0;
        bit_cnt_nxt = '0;
        ld_count_nxt = '0;
      end
      SHIFT: if (cs_rise) begin
        state_nxt = IDLE;
        released_nxt = released | (ld_count != '0);
      end else if (sclk_rise) begin
        shift_nxt = {shift[6:0], sdi_s};
        bit_cnt_nxt = bit_cnt + 3'd1;
        state_nxt = (bit_cnt == 3'd7) ? WRITE : SHIFT;
      end
      WRITE: begin
        ptr_nxt = ptr + 1'b1;
        ld_count_nxt = ld_count_inc;
        bit_cnt_nxt = '0;
        state_nxt = cs_rise ? IDLE : SHIFT;
        released_nxt = released | cs_rise;
      end
      default: state_nxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_cpu_prog_mem_responder.sv
// tb_cpu_prog_mem_responder: directed loader frames with a scoreboard of expected read bytes
module tb_cpu_prog_mem_responder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [9:0] addr_bus = 10'h3ff;
  logic [7:0] data_bus;
  logic ld_cs_n = 1'b1, ld_sclk = 1'b0, ld_sdi = 1'b0;
  logic cpu_hold;
  logic [6:0] ld_count;
  typedef struct {string tag; logic [7:0] val;} exp_t;
  exp_t sb[$];
  logic [7:0] mem_m [64];
  int m_ptr, m_cnt;
  int checks = 0, errors = 0;

  cpu_prog_mem_responder dut (
    .clk(clk), .rst_n(rst_n), .addr_bus(addr_bus), .data_bus(data_bus),
    .ld_cs_n(ld_cs_n), .ld_sclk(ld_sclk), .ld_sdi(ld_sdi),
    .cpu_hold(cpu_hold), .ld_count(ld_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [9:0] a, input string tag);
    exp_t e;
    @(negedge clk);
    addr_bus = a;
    sb.push_back('{tag, (a < 10'd64) ? mem_m[a[5:0]] : 8'h00});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk(e.tag, data_bus, e.val);
  endtask

  task automatic send_bit(input logic b);
    ld_sdi = b;
    repeat (4) @(posedge clk);
    ld_sclk = 1'b1;
    repeat (4) @(posedge clk);
    ld_sclk = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    mem_m[m_ptr] = b;
    m_ptr = (m_ptr + 1) % 64;
    m_cnt = (m_cnt < 64) ? m_cnt + 1 : 64;
  endtask

  task automatic begin_frame();
    ld_cs_n = 1'b0;
    m_ptr = 0;
    m_cnt = 0;
    repeat (6) @(posedge clk);
  endtask

  task automatic end_frame(input string tag);
    int n;
    repeat (4) @(posedge clk);
    ld_cs_n = 1'b1;
    n = 0;
    while (cpu_hold && n < 20) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk({tag, "_hold"}, {7'd0, cpu_hold}, 8'h00);
    chk({tag, "_count"}, {1'b0, ld_count}, 8'(m_cnt));
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("rst_hold", {7'd0, cpu_hold}, 8'h01);
    chk("rst_data", data_bus, 8'h00);
    chk("rst_count", {1'b0, ld_count}, 8'h00);

    begin_frame();
    chk("frame_hold", {7'd0, cpu_hold}, 8'h01);
    send_byte(8'ha5);
    send_byte(8'h3c);
    send_byte(8'hff);
    end_frame("basic");
    rd(10'd0, "basic_rd0");
    rd(10'd1, "basic_rd1");
    rd(10'd2, "basic_rd2");

    begin_frame();
    chk("partial_inframe_hold", {7'd0, cpu_hold}, 8'h01);
    chk("partial_inframe_count", {1'b0, ld_count}, 8'h00);
    send_byte(8'h11);
    send_byte(8'h22);
    for (int i = 0; i < 5; i++) send_bit(i[0]);
    end_frame("partial");
    rd(10'd0, "partial_rd0");
    rd(10'd1, "partial_rd1");
    rd(10'd2, "partial_rd2");

    begin_frame();
    end_frame("empty");

    begin_frame();
    for (int i = 0; i < 66; i++) send_byte(8'(i));
    end_frame("wrap");
    rd(10'd0, "wrap_rd0");
    rd(10'd1, "wrap_rd1");
    rd(10'd2, "wrap_rd2");
    rd(10'd63, "wrap_rd63");

    rd(10'h040, "oor_040");
    rd(10'h3ff, "oor_3ff");
    rd(10'h07f, "oor_07f");

    begin_frame();
    send_byte(8'h5a);
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("midrst_hold", {7'd0, cpu_hold}, 8'h01);
    chk("midrst_count", {1'b0, ld_count}, 8'h00);
    chk("midrst_data", data_bus, 8'h00);
    ld_cs_n = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("midrst_still_held", {7'd0, cpu_hold}, 8'h01);
    rd(10'd0, "midrst_rd0");
    begin_frame();
    send_byte(8'hc3);
    send_byte(8'h7e);
    end_frame("reload");
    rd(10'd0, "reload_rd0");
    rd(10'd1, "reload_rd1");
    rd(10'd2, "reload_rd2");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/cpu_prog_mem_responder.md
Name: cpu_prog_mem_responder

Overview:
- Memory-side responder for the CPU's external program/data bus.
- The CPU drives a 10-bit address and samples an 8-bit data bus. This block answers each address with a byte from an internal byte array.
- The array is filled at bring-up through a slow 3-wire serial loader (cs_n/sclk/sdi) driven from GPIO.
- While a load frame is active, the CPU is held in reset.

Parameters:
- ADDR_W, 10, width of the CPU address bus.
- DEPTH, 64, number of implemented bytes (power of two, at most 2^ADDR_W).
- FILL, 8'h00, byte returned for addresses at or above DEPTH.

Ports:
- clk  input  1  system clock, same clock as the CPU
- rst_n  input  1  asynchronous active-low reset
- addr_bus  input  ADDR_W  address driven by the CPU
- data_bus  output  8  read data returned to the CPU
- ld_cs_n  input  1  loader frame select, active low, asynchronous to clk
- ld_sclk  input  1  loader bit clock, asynchronous, at most clk/8
- ld_sdi  input  1  loader serial data, MSB first
- cpu_hold  output  1  high = hold the CPU in reset
- ld_count  output  $clog2(DEPTH)+1  bytes written in the current or most recent frame, saturating at DEPTH

Behaviour:
- Reset (rst_n low, asynchronous):
  - data_bus=8'h00, cpu_hold=1, ld_count=0.
  - Write pointer=0, bit counter=0, shift register=0, synchroniser flops=idle (cs_n=1, sclk=0).
  - Memory contents are not reset and are undefined until loaded.
- After reset release, cpu_hold stays 1 until the first complete frame ends (cs_n rising edge seen with at least one byte written). After that, cpu_hold follows the frame state.
- Read path:
  - Registered with 1-cycle latency: data_bus <= (addr_bus < DEPTH) ? mem[addr_bus] : FILL on every clk edge.
  - Address bits above $clog2(DEPTH) must be zero for an in-range hit. There is no aliasing.
  - Read during write to the same address returns the old byte (read-before-write).
- Synchronisation: ld_cs_n, ld_sclk and ld_sdi each pass through a 2-flop synchroniser. A third flop on sclk provides rising-edge detection. All loader logic uses only the synchronised copies.
- Loader FSM states:
  - IDLE: cs_s=1, cpu_hold per the reset/first-frame rule above.
  - SHIFT: entered on a cs_s falling edge. On entry, pointer=0, bit counter=0, ld_count=0, cpu_hold=1. On each sclk_s rising edge, shift <= {shift[6:0], sdi_s} and bit counter +1.
  - WRITE: one cycle after the 8th bit. mem[pointer] <= shift; pointer+1 wrapping modulo DEPTH; ld_count+1 saturating at DEPTH; bit counter=0; return to SHIFT.
  - cs_s rising edge in SHIFT or WRITE: go to IDLE. A partial byte (1-7 bits) is discarded without writing. cpu_hold drops to 0 on the cycle after IDLE is entered, unless no complete frame has ever finished.
- Boundaries:
  - More than DEPTH bytes in one frame: the pointer wraps and overwrites from address 0. ld_count stays at DEPTH.
  - sclk edge coincident with a cs_s rise: the cs rise wins and the bit is dropped.
  - cs_s falling while WRITE is pending: the write completes first, then the new frame restarts the pointer.
  - Empty frame (cs low then high with no bytes): no writes. cpu_hold returns to its previous released/held status.
  - rst_n asserted mid-frame: the FSM aborts to IDLE and cpu_hold=1. Already-written bytes remain in memory.
- Out-of-range addr_bus never affects the loader.

Test Plan:
- Reset then idle: hold rst_n low 3 cycles, release -> cpu_hold=1, data_bus=8'h00, ld_count=0 until a frame completes.
- Basic load: frame with bytes 8'hA5, 8'h3C, 8'hFF at sclk=clk/8 -> ld_count=3. cpu_hold falls about 4 cycles after cs_n rises. addr_bus=0,1,2 gives data_bus=A5,3C,FF one cycle after each address.
- Partial byte: 2 full bytes then 5 extra bits, cs_n high -> only addresses 0 and 1 written, address 2 keeps its prior value, ld_count=2.
- Wrap: DEPTH+2 bytes of value i (i=0..65) -> mem[0]=64, mem[1]=65, mem[2]=2, ld_count=64.
- Out-of-range read: addr_bus=10'h040 and 10'h3FF with DEPTH=64 -> data_bus=FILL (8'h00) one cycle later.
- Reset mid-frame: assert rst_n after byte 1 of a 3-byte frame -> cpu_hold=1, FSM in IDLE. mem[0] holds byte 1. A new frame then loads from address 0.
